// File: rtl/auction_vickrey_sched.sv
`default_nettype none
// ============================================================================
//  Module      : auction_vickrey_sched
//  Description : Sequential second-price (Vickrey) auction scheduler.
//                Holds a host-written bank of 2**LOGB bids of N bits and, on
//                start, scans it one bid per cycle through a single shared
//                compare/select path. Publishes the winner index (binary and
//                one-hot), the winning bid and the clearing price (the
//                second-highest bid) together with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module auction_vickrey_sched #(
    parameter int N    = 8,
    parameter int LOGB = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bid_we,
    input  logic [LOGB-1:0]      bid_addr,
    input  logic [N-1:0]         bid_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [LOGB-1:0]      winner,
    output logic [2**LOGB-1:0]   winner_onehot,
    output logic [N-1:0]         max_bid,
    output logic [N-1:0]         price
);

    // Bank depth and the index of the last entry; the scan ends on that index.
    localparam int              c_nb       = 2**LOGB;
    localparam logic [LOGB-1:0] c_last_idx = LOGB'(c_nb - 1);

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t          state_q,  state_d;
    logic [LOGB-1:0] idx_q,    idx_d;
    logic [N-1:0]    best_q,   best_d;
    logic [N-1:0]    second_q, second_d;
    logic [LOGB-1:0] widx_q,   widx_d;
    logic [N-1:0]    bank_q [c_nb];
    logic [N-1:0]    bank_d [c_nb];

    // Published results; these only change on the final scan edge.
    logic [LOGB-1:0] winner_q,  winner_d;
    logic [N-1:0]    max_bid_q, max_bid_d;
    logic [N-1:0]    price_q,   price_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    // ------------------------------------------------------------------------
    // Shared compare/select path, fed by the bank entry under the scan index
    // ------------------------------------------------------------------------
    logic [N-1:0]    w_cur_bid;
    logic            w_gt_best;
    logic            w_gt_second;
    logic            w_last;
    logic [N-1:0]    w_best_nxt;
    logic [N-1:0]    w_second_nxt;
    logic [LOGB-1:0] w_widx_nxt;

    // Evaluate one bid against the running best/second; strict compares keep
    // the lowest index on a tie and push the tied value into second place.
    always_comb begin
        w_cur_bid    = bank_q[idx_q];
        w_gt_best    = (w_cur_bid > best_q);
        w_gt_second  = (w_cur_bid > second_q);
        w_last       = (idx_q == c_last_idx);
        w_best_nxt   = best_q;
        w_second_nxt = second_q;
        w_widx_nxt   = widx_q;
        if (w_gt_best) begin
            w_second_nxt = best_q;
            w_best_nxt   = w_cur_bid;
            w_widx_nxt   = idx_q;
        end else if (w_gt_second) begin
            w_second_nxt = w_cur_bid;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic for the controller, bank and result registers
    // ------------------------------------------------------------------------
    // Compute every next value; anything not explicitly updated holds.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        best_d    = best_q;
        second_d  = second_q;
        widx_d    = widx_q;
        bank_d    = bank_q;
        winner_d  = winner_q;
        max_bid_d = max_bid_q;
        price_d   = price_q;

        case (state_q)
            S_IDLE: begin
                // The host may only write the bank while no scan is running,
                // so a write and a start on the same edge scan the new value.
                if (bid_we) begin
                    bank_d[bid_addr] = bid_data;
                end
                if (start) begin
                    state_d  = S_SCAN;
                    idx_d    = '0;
                    best_d   = '0;
                    second_d = '0;
                    widx_d   = '0;
                end
            end

            S_SCAN: begin
                best_d   = w_best_nxt;
                second_d = w_second_nxt;
                widx_d   = w_widx_nxt;
                // Index wraps to zero on the terminal count.
                idx_d    = idx_q + LOGB'(1);
                if (w_last) begin
                    // Results take the values produced by this final edge,
                    // so the outputs never expose a partial scan.
                    state_d   = S_DONE;
                    winner_d  = w_widx_nxt;
                    max_bid_d = w_best_nxt;
                    price_d   = w_second_nxt;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d == S_SCAN);
        done_d = (state_d == S_DONE);
    end

    // Register all state; reset clears the bank and aborts any scan at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            best_q    <= '0;
            second_q  <= '0;
            widx_q    <= '0;
            winner_q  <= '0;
            max_bid_q <= '0;
            price_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < c_nb; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            best_q    <= best_d;
            second_q  <= second_d;
            widx_q    <= widx_d;
            winner_q  <= winner_d;
            max_bid_q <= max_bid_d;
            price_q   <= price_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < c_nb; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy    = busy_q;
    assign done    = done_q;
    assign winner  = winner_q;
    assign max_bid = max_bid_q;
    assign price   = price_q;

    // One-hot decode of the registered winner index.
    generate
        for (genvar i = 0; i < c_nb; i++) begin : g_onehot
            assign winner_onehot[i] = (winner_q == LOGB'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_auction_vickrey_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_auction_vickrey_sched
//  Description : Self-checking bench for auction_vickrey_sched. A table of
//                bid banks with hand-computed results, plus directed
//                sequences for ignored writes/starts, mid-scan reset and a
//                write landing on the same edge as start.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_auction_vickrey_sched;

    localparam int N    = 8;
    localparam int LOGB = 3;
    localparam int NB   = 2**LOGB;

    logic             clk;
    logic             rst_n;
    logic             bid_we;
    logic [LOGB-1:0]  bid_addr;
    logic [N-1:0]     bid_data;
    logic             start;
    logic             busy;
    logic             done;
    logic [LOGB-1:0]  winner;
    logic [NB-1:0]    winner_onehot;
    logic [N-1:0]     max_bid;
    logic [N-1:0]     price;

    int n_total = 0;
    int n_pass  = 0;

    auction_vickrey_sched #(.N(N), .LOGB(LOGB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bid_we        (bid_we),
        .bid_addr      (bid_addr),
        .bid_data      (bid_data),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .winner        (winner),
        .winner_onehot (winner_onehot),
        .max_bid       (max_bid),
        .price         (price)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [0:7][7:0]  bids;
        logic [2:0]       w;
        logic [7:0]       oh;
        logic [7:0]       mx;
        logic [7:0]       pr;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Load the whole bank, one entry per clock.
    task automatic write_bank(input logic [0:7][7:0] bids);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            bid_we   = 1'b1;
            bid_addr = LOGB'(i);
            bid_data = bids[i];
        end
        @(negedge clk);
        bid_we = 1'b0;
    endtask

    // Start a scan (optionally with a write on the same edge), follow it to
    // done, and check timing, result values and result stability.
    task automatic run_scan(input string nm, input bit wr, input logic [2:0] wa,
                            input logic [7:0] wd, input bit interfere,
                            input logic [2:0] ew, input logic [7:0] eoh,
                            input logic [7:0] emx, input logic [7:0] epr);
        logic [2:0] pw;
        logic [7:0] pm;
        logic [7:0] pp;
        int busy_cnt;
        int done_at;
        bit overlap;
        bit partial;
        pw = winner;
        pm = max_bid;
        pp = price;
        @(negedge clk);
        bid_we   = wr;
        bid_addr = wa;
        bid_data = wd;
        start    = 1'b1;
        @(negedge clk);
        bid_we   = 1'b0;
        start    = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        overlap  = 1'b0;
        partial  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                done_at = c;
                break;
            end
            if (busy) busy_cnt++;
            if (winner !== pw || max_bid !== pm || price !== pp) partial = 1'b1;
            if (interfere && busy) begin
                bid_we   = 1'b1;
                bid_addr = 3'd0;
                bid_data = 8'd255;
                start    = 1'b1;
            end
            @(negedge clk);
            bid_we = 1'b0;
            start  = 1'b0;
        end
        chk({nm, "_busy_cycles"}, busy_cnt, 8);
        chk({nm, "_done_cycle"}, done_at, 8);
        chk({nm, "_busy_done_overlap"}, {31'd0, overlap}, 0);
        chk({nm, "_no_partial"}, {31'd0, partial}, 0);
        chk({nm, "_winner"}, {29'd0, winner}, {29'd0, ew});
        chk({nm, "_onehot"}, {24'd0, winner_onehot}, {24'd0, eoh});
        chk({nm, "_max_bid"}, {24'd0, max_bid}, {24'd0, emx});
        chk({nm, "_price"}, {24'd0, price}, {24'd0, epr});
        if (interfere) begin
            bid_we   = 1'b1;
            bid_addr = 3'd0;
            bid_data = 8'd255;
            start    = 1'b1;
        end
        @(negedge clk);
        bid_we = 1'b0;
        start  = 1'b0;
        chk({nm, "_done_pulse_ends"}, {31'd0, done}, 0);
        chk({nm, "_idle_after_done"}, {31'd0, busy}, 0);
        chk({nm, "_max_bid_holds"}, {24'd0, max_bid}, {24'd0, emx});
        chk({nm, "_price_holds"}, {24'd0, price}, {24'd0, epr});
    endtask

    initial begin
        bit saw_done;

        vecs[0] = '{"t1_basic", {8'd10, 8'd50, 8'd30, 8'd20, 8'd0, 8'd5, 8'd40, 8'd1},
                    3'd1, 8'h02, 8'd50, 8'd40};
        vecs[1] = '{"t2_tie",   {8'd7, 8'd90, 8'd3, 8'd90, 8'd0, 8'd0, 8'd0, 8'd0},
                    3'd1, 8'h02, 8'd90, 8'd90};
        vecs[2] = '{"t3_zero",  {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                    3'd0, 8'h01, 8'd0, 8'd0};
        vecs[3] = '{"t3_single",{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255},
                    3'd7, 8'h80, 8'd255, 8'd0};

        rst_n    = 1'b0;
        bid_we   = 1'b0;
        bid_addr = '0;
        bid_data = '0;
        start    = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_winner", {29'd0, winner}, 0);
        chk("rst_onehot", {24'd0, winner_onehot}, 32'h01);
        chk("rst_max_bid", {24'd0, max_bid}, 0);
        chk("rst_price", {24'd0, price}, 0);
        rst_n = 1'b1;

        // Table-driven scans.
        for (int v = 0; v < 4; v++) begin
            write_bank(vecs[v].bids);
            run_scan(vecs[v].name, 1'b0, 3'd0, 8'd0, 1'b0,
                     vecs[v].w, vecs[v].oh, vecs[v].mx, vecs[v].pr);
        end

        // Writes and starts during SCAN/DONE are ignored; the bank keeps 10.
        write_bank(vecs[0].bids);
        run_scan("t4_interfere", 1'b0, 3'd0, 8'd0, 1'b1, 3'd1, 8'h02, 8'd50, 8'd40);
        run_scan("t4_rescan", 1'b0, 3'd0, 8'd0, 1'b0, 3'd1, 8'h02, 8'd50, 8'd40);

        // Asynchronous reset in the fourth SCAN cycle.
        write_bank(vecs[0].bids);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_busy_before_reset", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_busy", {31'd0, busy}, 0);
        chk("t5_async_done", {31'd0, done}, 0);
        chk("t5_async_winner", {29'd0, winner}, 0);
        chk("t5_async_onehot", {24'd0, winner_onehot}, 32'h01);
        chk("t5_async_max_bid", {24'd0, max_bid}, 0);
        chk("t5_async_price", {24'd0, price}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("t5_no_done_after_abort", {31'd0, saw_done}, 0);
        run_scan("t5_fresh", 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'h01, 8'd0, 8'd0);

        // Write and start on the same IDLE edge; the scan sees the new bid.
        run_scan("t6_write_start", 1'b1, 3'd2, 8'd77, 1'b0, 3'd2, 8'h04, 8'd77, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
